flex_down_timer: RTL and testbench
==================================

FLEX_DOWN_TIMER -- requirements
Module: flex_down_timer

Interface
REQ-001 Parameter NUM_CNT_BITS SHALL be declared with default 4; it sets the width of the counter, load value and reload register.
REQ-002 clk  input  1  SHALL be the system clock; all state SHALL update on its rising edge.
REQ-003 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 clear  input  1  SHALL be a synchronous abort that forces the timer idle.
REQ-005 start  input  1  SHALL be a single-cycle request to load load_val and begin counting.
REQ-006 count_enable  input  1  SHALL be the decrement strobe; the count SHALL hold when it is low.
REQ-007 periodic  input  1  SHALL select the mode, sampled at start: 1 = auto-reload, 0 = one-shot.
REQ-008 load_val  input  NUM_CNT_BITS  SHALL be the start value, sampled when start is accepted.
REQ-009 count_out  output  NUM_CNT_BITS  SHALL be the registered current count.
REQ-010 busy  output  1  SHALL be registered and high while in RUN.
REQ-011 expire_flag  output  1  SHALL be a registered one-cycle pulse on each expiry.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and RUN, and SHALL drive busy = (state == RUN).
REQ-013 Per-edge priority SHALL be: clear, then start, then decrement, then hold.
REQ-014 clear=1 SHALL set on the next edge: state IDLE, count_out 0, expire_flag 0, and reload register 0.
REQ-015 On an accepted start with load_val != 0, the next edge SHALL set: count_out=load_val, reload register=load_val, mode latch=periodic, state RUN, expire_flag 0.
REQ-016 On an accepted start with load_val == 0, the next edge SHALL set: count_out 0, state IDLE, expire_flag 1 for exactly one cycle.
REQ-017 start SHALL be accepted in both IDLE and RUN; in RUN it SHALL restart the timer with the new load_val and mode, and no expiry SHALL be signalled for the abandoned run.
REQ-018 In RUN with count_enable=1 and count_out > 1, count_out SHALL decrement by 1 per edge.
REQ-019 Expiry SHALL occur in RUN when count_enable=1 and count_out == 1; on that edge expire_flag SHALL go to 1 for exactly one cycle.
REQ-020 On expiry in one-shot mode, count_out SHALL become 0 and state SHALL go to IDLE on the same edge.
REQ-021 On expiry in periodic mode, count_out SHALL reload from the reload register and state SHALL remain RUN, giving a period of exactly reload count_enable strobes.
REQ-022 In IDLE without start, count_out SHALL hold its value; count_enable and periodic SHALL be ignored.
REQ-023 expire_flag SHALL be 0 on every edge where no expiry is defined by REQ-016 or REQ-019.
REQ-024 Loads SHALL wrap nothing: all-ones load_val SHALL count down from 2^NUM_CNT_BITS-1 with no overflow or sign extension.
REQ-025 Changes on periodic or load_val after start is accepted SHALL have no effect until the next start.

Reset
REQ-026 While n_rst=0 the block SHALL hold, independent of clk: state IDLE, count_out 0, busy 0, expire_flag 0, reload register 0, mode latch 0.
REQ-027 Reset asserted mid-run SHALL abandon the run immediately and SHALL produce no expire_flag pulse.
REQ-028 After reset deasserts, the block SHALL be idle until the first start.

Verification (NUM_CNT_BITS=4)
REQ-029 One-shot: start, load_val=3, periodic=0, count_enable held 1 -> count_out 3,2,1,0; expire_flag=1 on the edge count_out reaches 0; busy falls on that same edge.
REQ-030 Periodic: load_val=2, periodic=1, enable=1 for 6 cycles -> count_out 2,1,2,1,2,1; one expire pulse every 2 cycles; busy stays 1.
REQ-031 Gated enable: load_val=4 with enable toggled 1,0,1,0 -> count_out 4,3,3,2,2; no expire pulse.
REQ-032 Restart and clear: restart with start at count_out=2 using load_val=15 -> count_out 15 and no expire pulse. Then assert clear together with start -> IDLE, count_out 0, busy 0.
REQ-033 Zero load and reset: start with load_val=0 -> single expire pulse and busy stays 0. Assert n_rst low mid-run at count_out=5 -> all outputs 0 immediately.

Source files
------------

// File: rtl/flex_down_timer.sv
// flex_down_timer: loadable down-counter with one-shot and auto-reload modes.
//
// A start request loads load_val and begins counting down on each
// count_enable strobe. When the count would pass from 1 to 0, the timer
// expires: expire_flag pulses for one cycle, and then
//   - one-shot mode: the count goes to 0 and the timer goes idle
//   - periodic mode: the count reloads from the value captured at start
// A start with load_val == 0 expires immediately and leaves the timer idle.
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   clear         synchronous abort to idle (highest priority)
//   start         single-cycle load-and-run request (restarts a running timer)
//   count_enable  decrement strobe
//   periodic      mode select, sampled at start (1 = auto-reload)
//   load_val      start value, sampled at start
//   count_out     registered current count
//   busy          registered, high while running
//   expire_flag   registered one-cycle expiry pulse
//
// state | meaning
// IDLE  | not counting; count_out holds, strobes ignored
// RUN   | counting down on count_enable
module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    count_enable,
    input  logic                    periodic,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    expire_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    state_t                  state_q,  state_d;
    logic [NUM_CNT_BITS-1:0] count_q,  count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    mode_q,   mode_d;
    logic                    expire_q, expire_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            count_d  = CNT_ZERO;
            reload_d = CNT_ZERO;
        end else if (start) begin
            // A restart simply overwrites the running count, so the
            // abandoned run can never produce an expiry.
            if (load_val != CNT_ZERO) begin
                state_d  = RUN;
                count_d  = load_val;
                reload_d = load_val;
                mode_d   = periodic;
            end else begin
                state_d  = IDLE;
                count_d  = CNT_ZERO;
                expire_d = 1'b1;
            end
        end else if (state_q == RUN && count_enable) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
                expire_d = 1'b1;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = CNT_ZERO;
                    state_d = IDLE;
                end
            end
        end
    end

    assign count_out   = count_q;
    assign busy        = (state_q == RUN);
    assign expire_flag = expire_q;

endmodule

// File: tb/tb_flex_down_timer.sv
module tb_flex_down_timer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         count_enable = 1'b0;
    logic         periodic = 1'b0;
    logic [N-1:0] load_val = '0;
    logic [N-1:0] count_out;
    logic         busy;
    logic         expire_flag;

    int n_cmp = 0;
    int n_bad = 0;

    flex_down_timer #(.NUM_CNT_BITS(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .start        (start),
        .count_enable (count_enable),
        .periodic     (periodic),
        .load_val     (load_val),
        .count_out    (count_out),
        .busy         (busy),
        .expire_flag  (expire_flag)
    );

    always #5 clk = ~clk;

    // Reference model: "strobes remaining until expiry" plus a running flag.
    int m_left;
    int m_period;
    bit m_running;
    bit m_auto;
    bit m_pulse;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_left = 0; m_period = 0; m_running = 0; m_auto = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (clear) begin
                m_left = 0; m_period = 0; m_running = 0;
            end else if (start) begin
                if (int'(load_val) == 0) begin
                    m_left = 0; m_running = 0; m_pulse = 1;
                end else begin
                    m_left = int'(load_val); m_period = int'(load_val);
                    m_auto = periodic; m_running = 1;
                end
            end else if (m_running && count_enable) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_pulse = 1;
                    if (m_auto) m_left = m_period;
                    else        m_running = 0;
                end
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            n_cmp++;
            if (count_out !== N'(m_left) || busy !== m_running || expire_flag !== m_pulse) begin
                n_bad++;
                $display("FAIL model t=%0t: got cnt=%0d busy=%0b exp=%0b, want cnt=%0d busy=%0b exp=%0b",
                         $time, count_out, busy, expire_flag, m_left, m_running, m_pulse);
            end
        end
    end

    task automatic lit(input string name, input int cnt, input bit b, input bit e);
        n_cmp++;
        if (count_out !== N'(cnt) || busy !== b || expire_flag !== e) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d busy=%0b exp=%0b, want cnt=%0d busy=%0b exp=%0b",
                     name, count_out, busy, expire_flag, cnt, b, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit st, input bit clr, input bit en, input bit per, input int lv);
        start = st; clear = clr; count_enable = en; periodic = per; load_val = N'(lv);
    endtask

    initial begin
        // Reset state
        #3;
        lit("reset_hold", 0, 0, 0);
        tick();
        lit("reset_clocked", 0, 0, 0);
        n_rst = 1'b1;
        tick();
        lit("idle_after_reset", 0, 0, 0);
        chk_en = 1;

        // One-shot, load 3
        begin
            int exp_c[4] = '{3, 2, 1, 0};
            bit exp_b[4] = '{1, 1, 1, 0};
            bit exp_e[4] = '{0, 0, 0, 1};
            drive(1, 0, 1, 0, 3);
            tick();
            drive(0, 0, 1, 0, 0);
            for (int i = 0; i < 4; i++) begin
                lit($sformatf("oneshot_%0d", i), exp_c[i], exp_b[i], exp_e[i]);
                if (i < 3) tick();
            end
            tick();
            lit("oneshot_after", 0, 0, 0);
        end

        // Periodic, load 2
        begin
            int exp_c[6] = '{2, 1, 2, 1, 2, 1};
            bit exp_e[6] = '{0, 0, 1, 0, 1, 0};
            drive(1, 0, 1, 1, 2);
            tick();
            drive(0, 0, 1, 0, 9);
            for (int i = 0; i < 6; i++) begin
                lit($sformatf("periodic_%0d", i), exp_c[i], 1, exp_e[i]);
                if (i < 5) tick();
            end
            drive(0, 1, 1, 0, 0);
            tick();
            lit("periodic_clear", 0, 0, 0);
        end

        // Gated enable, load 4
        begin
            int exp_c[5] = '{4, 3, 3, 2, 2};
            bit en_s[5]  = '{1, 0, 1, 0, 0};
            drive(1, 0, 0, 0, 4);
            tick();
            for (int i = 0; i < 5; i++) begin
                drive(0, 0, en_s[i], 1, 1);
                lit($sformatf("gated_%0d", i), exp_c[i], 1, 0);
                if (i < 4) tick();
            end
        end

        // Restart at count 2 with 15, then clear beats start
        drive(1, 0, 1, 0, 15);
        tick();
        lit("restart_15", 15, 1, 0);
        drive(0, 0, 1, 0, 0);
        tick();
        lit("restart_dec", 14, 1, 0);
        drive(1, 1, 1, 1, 7);
        tick();
        lit("clear_and_start", 0, 0, 0);

        // Zero load
        drive(1, 0, 1, 1, 0);
        tick();
        lit("zero_load", 0, 0, 1);
        drive(0, 0, 1, 1, 0);
        tick();
        lit("zero_load_after", 0, 0, 0);

        // Reset mid-run at count 5
        drive(1, 0, 1, 0, 7);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        tick();
        lit("pre_reset_5", 5, 1, 0);
        n_rst = 1'b0;
        #1;
        lit("reset_midrun", 0, 0, 0);
        tick();
        lit("reset_midrun_clk", 0, 0, 0);
        n_rst = 1'b1;
        tick();
        lit("post_reset_idle", 0, 0, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int lv;
            lv = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) lv = ($urandom_range(0, 1) == 0) ? 0 : 15;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, lv);
            if ($urandom_range(0, 249) == 0) begin
                n_rst = 1'b0;
                tick();
                n_rst = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
